// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types, constants and helpers for the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A fetch address is legal when word aligned and inside the memory.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] mem_words);
        return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < mem_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small prefetch FIFO of {pc, instr} entries with flush.
//               Head reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  fetch_entry_t       i_data,
    output fetch_entry_t       o_head,
    output logic               o_empty,
    output logic               o_full,
    output logic [CNT_W-1:0]   o_count
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(FIFO_DEPTH);

    fetch_entry_t     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_depth);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Entry storage; flushed entries are simply abandoned via the pointers.
    always_ff @(posedge clk_i) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush dominates push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch sequencer: owns the PC, fetches from a
//               combinational instruction memory into a prefetch FIFO,
//               handles redirects and flags illegal fetch addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          MEM_SIZE   = 80,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        halt_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fetch_err_o,
    output logic [31:0] fault_pc_o
);

    localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] c_mem_words = 32'(MEM_SIZE);
    localparam logic [0:0]  S_FETCH     = FETCH;
    localparam logic [0:0]  S_FAULT     = FAULT;

    logic [0:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_fault_pc;

    logic             w_pc_legal;
    logic             w_target_legal;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_head;
    fetch_entry_t     w_new;
    logic             w_unused;

    assign imem_addr_o    = r_pc;
    assign w_pc_legal     = pc_legal(r_pc, c_mem_words);
    assign w_target_legal = pc_legal(redirect_pc_i, c_mem_words);

    // A handshake coinciding with a redirect is discarded by the flush.
    assign w_pop  = !w_empty && instr_ready_i && !redirect_valid_i;
    assign w_push = (r_state == S_FETCH) && w_pc_legal && !halt_i &&
                    !redirect_valid_i && (!w_full || w_pop);

    assign w_new.pc    = r_pc;
    assign w_new.instr = imem_instr_i;

    assign instr_valid_o = !w_empty;
    assign instr_o       = w_head.instr;
    assign instr_pc_o    = w_head.pc;
    assign fetch_err_o   = (r_state == S_FAULT);
    assign fault_pc_o    = r_fault_pc;

    // Occupancy is tracked by empty/full here; the raw count is not needed.
    assign w_unused = &{1'b0, w_count};

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid_i),
        .i_data  (w_new),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // PC sequencing and FETCH/FAULT state machine; redirect has top priority.
    // A redirect out of FAULT only leaves FAULT when its target is legal;
    // a redirect from FETCH to an illegal target faults one edge later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_fault_pc <= '0;
        end else if (redirect_valid_i) begin
            r_pc <= redirect_pc_i;
            if ((r_state == S_FAULT) && !w_target_legal) begin
                r_fault_pc <= redirect_pc_i;
            end else begin
                r_state <= S_FETCH;
            end
        end else if ((r_state == S_FETCH) && !w_pc_legal) begin
            r_state    <= S_FAULT;
            r_fault_pc <= r_pc;
        end else if (w_push) begin
            r_pc <= r_pc + 32'(INSTR_BYTES);
        end
    end

endmodule
`default_nettype wire
